// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation result path.
package me_pkg;
    localparam int ME_MV_WIDTH   = 5;
    localparam int ME_SAD_WIDTH  = 16;
    localparam int ME_DW         = 2 * ME_MV_WIDTH + ME_SAD_WIDTH;
    localparam int ME_FRAME_BITS = ME_DW + 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } me_state_e;
endpackage

// File: rtl/me_bit_timer.sv
// Bit-period down-counter; bit_end marks the last cycle of every serial bit.
module me_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic start,
    input  logic run,
    output logic bit_end
);
    localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt;

    // Auto-reload on terminal count so consecutive bits need no restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (start) begin
            cnt <= RELOAD;
        end else if (run) begin
            cnt <= (cnt == 8'd0) ? RELOAD : cnt - 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    assign bit_end = run && (cnt == 8'd0);
endmodule

// File: rtl/me_result_serializer.sv
// Serial transmitter for per-block motion-estimation results: start, LSB-first
// data {mv_x, mv_y, sad}, even parity, stop; one-entry holding register.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, waiting for a result
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out, index bit_idx
// ST_PARITY | driving the stored even-parity bit
// ST_STOP   | driving the stop bit (1); chains to the next word if held
module me_result_serializer
    import me_pkg::*;
#(
    parameter int MV_WIDTH   = ME_MV_WIDTH,
    parameter int SAD_WIDTH  = ME_SAD_WIDTH,
    parameter int BIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [MV_WIDTH-1:0]  res_mv_x,
    input  logic [MV_WIDTH-1:0]  res_mv_y,
    input  logic [SAD_WIDTH-1:0] res_sad,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int DW    = 2 * MV_WIDTH + SAD_WIDTH;
    localparam int IDX_W = $clog2(DW);

    me_state_e        state;
    logic [DW-1:0]    shift_reg;
    logic             shift_par;
    logic [DW-1:0]    hold_word;
    logic             hold_par;
    logic             hold_full;
    logic [IDX_W-1:0] bit_idx;

    logic [DW-1:0]    in_word;
    logic             hs;
    logic             load_idle;
    logic             stop_end;
    logic             hold_load;
    logic             bit_end;

    assign in_word   = {res_mv_x, res_mv_y, res_sad};
    assign res_ready = !hold_full || init;
    assign hs        = res_valid && !hold_full && !init;
    assign load_idle = hs && (state == ST_IDLE);
    assign stop_end  = (state == ST_STOP) && bit_end;
    // A handshake on the closing edge of a stop bit with nothing held goes
    // straight to the shift register, otherwise IDLE could be entered full.
    assign hold_load = hs && (state != ST_IDLE) && !stop_end;

    assign busy       = (state != ST_IDLE) || hold_full;
    assign frame_done = stop_end && !init;

    me_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (init),
        .start  (load_idle),
        .run    (state != ST_IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            shift_par  <= 1'b0;
            hold_word  <= '0;
            hold_par   <= 1'b0;
            hold_full  <= 1'b0;
            bit_idx    <= '0;
            serial_out <= 1'b1;
        end else if (init) begin
            state      <= ST_IDLE;
            hold_full  <= 1'b0;
            bit_idx    <= '0;
            serial_out <= 1'b1;
        end else begin
            if (hold_load) begin
                hold_word <= in_word;
                hold_par  <= ^in_word;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        shift_reg  <= in_word;
                        shift_par  <= ^in_word;
                        state      <= ST_START;
                        serial_out <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                        bit_idx    <= '0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DW - 1)) begin
                            serial_out <= shift_par;
                            state      <= ST_PARITY;
                        end else begin
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                            bit_idx    <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        serial_out <= 1'b1;
                        state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (hold_full) begin
                            shift_reg  <= hold_word;
                            shift_par  <= hold_par;
                            hold_full  <= 1'b0;
                            serial_out <= 1'b0;
                            state      <= ST_START;
                        end else if (hs) begin
                            shift_reg  <= in_word;
                            shift_par  <= ^in_word;
                            serial_out <= 1'b0;
                            state      <= ST_START;
                        end else begin
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_me_result_serializer.sv
// Bench for me_result_serializer: line activity is logged per cycle and
// compared against a frame model built from the word, parity and bit timing.
module tb_me_result_serializer;
    import me_pkg::*;

    localparam int BC   = 4;
    localparam int DW   = ME_DW;
    localparam int FC   = ME_FRAME_BITS * BC;
    localparam int LOGN = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        res_valid = 1'b0;
    logic [4:0]  res_mv_x = '0;
    logic [4:0]  res_mv_y = '0;
    logic [15:0] res_sad = '0;
    logic        res_ready, serial_out, busy, frame_done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic log_so   [LOGN];
    logic log_fd   [LOGN];
    logic log_rdy  [LOGN];
    logic log_busy [LOGN];

    me_result_serializer #(
        .MV_WIDTH(5), .SAD_WIDTH(16), .BIT_CYCLES(BC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init(init),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad),
        .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_so[cyc]   = serial_out;
            log_fd[cyc]   = frame_done;
            log_rdy[cyc]  = res_ready;
            log_busy[cyc] = busy;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d want completion", cyc);
        $fatal(1, "watchdog");
    end

    // Expected line level j cycles after the handshake (j = 0 is the first start-bit cycle).
    function automatic logic line_model(input logic [DW-1:0] d, input int j);
        int b;
        b = j / BC;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (b == DW + 1) return ^d;
        return 1'b1;
    endfunction

    function automatic int line_errs(input int h, input logic [DW-1:0] d);
        int e;
        e = 0;
        for (int j = 0; j < FC; j++) begin
            if (h + j >= LOGN) e++;
            else begin
                if (log_so[h+j] !== line_model(d, j)) e++;
                if (log_fd[h+j] !== (j == FC - 1)) e++;
            end
        end
        return e;
    endfunction

    // Mid-bit sampling receiver: returns {parity, data}.
    function automatic logic [DW:0] decode(input int h);
        logic [DW:0] r;
        r = '0;
        for (int b = 1; b <= DW + 1; b++)
            if (h + b * BC + BC / 2 < LOGN) r[b-1] = log_so[h + b * BC + BC / 2];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic offer(input logic [DW-1:0] w, output int h);
        bit ok;
        ok = 1'b0;
        h = 0;
        {res_mv_x, res_mv_y, res_sad} = w;
        res_valid = 1'b1;
        for (int i = 0; i < 4 * FC && !ok; i++) begin
            if (res_ready === 1'b1) begin
                tick();
                h = cyc;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        res_valid = 1'b0;
        {res_mv_x, res_mv_y, res_sad} = DW'($urandom);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL handshake_timeout: res_ready never high, word %h", w);
        end
    endtask

    task automatic test_reset();
        int s, e_so, e_rdy, e_busy;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial_out: got %b want 1", serial_out); end
        n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", res_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst_n = 1'b1;
        s = cyc;
        repeat (51) tick();
        e_so = 0; e_rdy = 0; e_busy = 0;
        for (int i = s; i < s + 50; i++) begin
            if (log_so[i] !== 1'b1) e_so++;
            if (log_rdy[i] !== 1'b1) e_rdy++;
            if (log_busy[i] !== 1'b0) e_busy++;
        end
        n_cmp++; if (e_so != 0) begin n_fail++; $display("FAIL idle_line: %0d cycles not high, want 0", e_so); end
        n_cmp++; if (e_rdy != 0) begin n_fail++; $display("FAIL idle_ready: %0d cycles not ready, want 0", e_rdy); end
        n_cmp++; if (e_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d cycles busy, want 0", e_busy); end
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] w;
        logic [DW:0]   r;
        int h, e;
        w = {5'b11101, 5'b00111, 16'h1234};
        offer(w, h);
        wait_until(h + FC + 4);
        e = line_errs(h, w);
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL single_frame_line: %0d sample errors, want 0", e); end
        r = decode(h);
        n_cmp++; if (r[DW-1:0] !== w) begin n_fail++; $display("FAIL single_decode: got %h want %h", r[DW-1:0], w); end
        n_cmp++; if (r[DW] !== 1'b0) begin n_fail++; $display("FAIL single_parity: got %b want 0", r[DW]); end
        n_cmp++; if (log_fd[h + FC - 1] !== 1'b1) begin n_fail++; $display("FAIL single_frame_done_116: got %b want 1", log_fd[h + FC - 1]); end
        n_cmp++; if (log_so[h + FC] !== 1'b1 || log_busy[h + FC] !== 1'b0) begin
            n_fail++; $display("FAIL single_after_idle: line %b busy %b want 1 0", log_so[h + FC], log_busy[h + FC]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w1, w2, w3;
        logic [DW:0]   r;
        int h1, h2, h3, e_rdy, e_busy, e;
        w1 = DW'($urandom);
        w2 = {5'd15, 5'b10000, 16'hFFFF};
        w3 = DW'($urandom);
        offer(w1, h1);
        repeat (10) tick();
        offer(w2, h2);
        offer(w3, h3);
        n_cmp++; if (h3 != h1 + FC + 1) begin n_fail++; $display("FAIL b2b_third_accept: got cycle %0d want %0d", h3 - h1, FC + 1); end
        wait_until(h1 + 3 * FC + 4);
        e_rdy = 0;
        for (int i = h2; i < h1 + FC; i++) if (log_rdy[i] !== 1'b0) e_rdy++;
        for (int i = h3; i < h1 + 2 * FC; i++) if (log_rdy[i] !== 1'b0) e_rdy++;
        if (log_rdy[h1 + FC] !== 1'b1) e_rdy++;
        n_cmp++; if (e_rdy != 0) begin n_fail++; $display("FAIL b2b_ready: %0d cycles wrong, want 0", e_rdy); end
        e_busy = 0;
        for (int i = h1; i < h1 + 3 * FC; i++) if (log_busy[i] !== 1'b1) e_busy++;
        n_cmp++; if (e_busy != 0) begin n_fail++; $display("FAIL b2b_busy: %0d cycles not busy, want 0", e_busy); end
        e = line_errs(h1, w1);
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL b2b_frame1: %0d sample errors, want 0", e); end
        e = line_errs(h1 + FC, w2);
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL b2b_frame2: %0d sample errors, want 0", e); end
        e = line_errs(h1 + 2 * FC, w3);
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL b2b_frame3: %0d sample errors, want 0", e); end
        r = decode(h1 + FC);
        n_cmp++; if (r !== {1'b1, w2}) begin n_fail++; $display("FAIL b2b_decode2: got %h want %h", r, {1'b1, w2}); end
    endtask

    task automatic test_init_abort();
        logic [DW-1:0] w1, w2, w4;
        int h, h2, h4, e_line, e_fd;
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        offer(w1, h);
        repeat (4) tick();
        offer(w2, h2);
        wait_until(h + 39);
        init = 1'b1;
        res_valid = 1'b1;
        {res_mv_x, res_mv_y, res_sad} = DW'($urandom);
        #1;
        n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready: got %b want 1", res_ready); end
        tick();
        init = 1'b0;
        res_valid = 1'b0;
        wait_until(h + FC + 22);
        n_cmp++; if (log_so[h + 40] !== 1'b1 || log_busy[h + 40] !== 1'b0) begin
            n_fail++; $display("FAIL init_abort: line %b busy %b want 1 0", log_so[h + 40], log_busy[h + 40]);
        end
        e_line = 0; e_fd = 0;
        for (int i = h + 40; i < h + FC + 20; i++) if (log_so[i] !== 1'b1 || log_busy[i] !== 1'b0) e_line++;
        for (int i = h; i < h + FC + 20; i++) if (log_fd[i] !== 1'b0) e_fd++;
        n_cmp++; if (e_line != 0) begin n_fail++; $display("FAIL init_stays_idle: %0d cycles active, want 0", e_line); end
        n_cmp++; if (e_fd != 0) begin n_fail++; $display("FAIL init_no_frame_done: %0d pulses, want 0", e_fd); end
        w4 = DW'($urandom);
        offer(w4, h4);
        wait_until(h4 + FC + 4);
        e_line = line_errs(h4, w4);
        n_cmp++; if (e_line != 0) begin n_fail++; $display("FAIL init_next_frame: %0d sample errors, want 0", e_line); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] w;
        logic [DW:0]   r;
        int h, e;
        w = '0;
        offer(w, h);
        wait_until(h + 20);
        #1;
        n_cmp++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL arst_pre_line: got %b want 0", serial_out); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL arst_line: got %b want 1", serial_out); end
        n_cmp++; if (busy !== 1'b0 || res_ready !== 1'b1) begin
            n_fail++; $display("FAIL arst_state: busy %b ready %b want 0 1", busy, res_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        w = {5'd0, 5'd0, 16'h0001};
        offer(w, h);
        wait_until(h + FC + 4);
        e = line_errs(h, w);
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL arst_next_frame: %0d sample errors, want 0", e); end
        r = decode(h);
        n_cmp++; if (r[DW] !== 1'b1) begin n_fail++; $display("FAIL arst_parity: got %b want 1", r[DW]); end
    endtask

    task automatic test_random_stream();
        logic [DW-1:0] w [6];
        int st [6];
        int h, e;
        for (int k = 0; k < 6; k++) begin
            w[k] = DW'($urandom);
            if (k == 2) wait_until(st[1] + FC - 1);
            else if (k > 0) repeat ($urandom_range(0, 140)) tick();
            offer(w[k], h);
            if (k == 0) st[k] = h;
            else st[k] = (h > st[k-1] + FC) ? h : st[k-1] + FC;
        end
        wait_until(st[5] + FC + 4);
        for (int k = 0; k < 6; k++) begin
            e = line_errs(st[k], w[k]);
            n_cmp++; if (e != 0) begin n_fail++; $display("FAIL random_frame%0d: %0d sample errors, want 0 (word %h)", k, e, w[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_init_abort();
        test_async_reset();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
